// File: rtl/misr_pkg.sv
// Shared definitions for the MISR compactor: default geometry, default
// feedback polynomial and the controller state encoding.
package misr_pkg;

  localparam int          MISR_WIDTH_DEF = 16;
  localparam int          MISR_CNT_W_DEF = 16;
  localparam logic [15:0] MISR_POLY_DEF  = 16'h1021;

  // States are prefixed so they never collide with the DONE status signal.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_e;

endpackage : misr_pkg

// File: rtl/misr_compactor_if.sv
// Control/data bundle between the test harness and the MISR compactor.
// master: harness side that drives the run; slave: the compactor.
interface misr_compactor_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic             START;
  logic [CNT_W-1:0] NCYC;
  logic [WIDTH-1:0] SEED;
  logic [WIDTH-1:0] DIN;
  logic             DIN_VLD;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SIG;

  modport master (
    output START, NCYC, SEED, DIN, DIN_VLD,
    input  BUSY, DONE, SIG
  );

  modport slave (
    input  START, NCYC, SEED, DIN, DIN_VLD,
    output BUSY, DONE, SIG
  );

endinterface : misr_compactor_if

// File: rtl/misr_next.sv
// Combinational next-signature XOR tree: shift left by one, fold the bit
// shifted out back in through the polynomial taps, then XOR the new sample.
module misr_next
  import misr_pkg::*;
#(
  parameter int WIDTH = MISR_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] sig_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic [WIDTH-1:0] sig_o
);

  logic fb;

  // Feedback bit is the MSB leaving the register.
  assign fb = sig_i[WIDTH-1];

  // Bit 0 has no shift-in source; a zero enters from the bottom.
  assign sig_o[0] = (fb & poly_i[0]) ^ din_i[0];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
      assign sig_o[gi] = sig_i[gi-1] ^ (fb & poly_i[gi]) ^ din_i[gi];
    end
  endgenerate

endmodule : misr_next

// File: rtl/misr_compactor.sv
// MISR compactor: a run-length controller folds a programmed number of valid
// samples into the signature, then freezes the result until the next START.
module misr_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DEF),
  parameter int               CNT_W = MISR_CNT_W_DEF
) (
  input logic              CLK,
  input logic              RSTB,
  misr_compactor_if.slave  bus
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] sig_q,   sig_d;
  logic [WIDTH-1:0] sig_nxt;

  misr_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .sig_i  (sig_q),
    .din_i  (bus.DIN),
    .poly_i (POLY),
    .sig_o  (sig_nxt)
  );

  // State, counter and signature registers; reset clears everything at once.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // Next-state logic: accept START when not running, fold valid samples in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          sig_d = bus.SEED;
          if (bus.NCYC == '0) begin
            // Zero-length run: the seed itself is the final signature.
            state_d = ST_DONE;
          end else begin
            cnt_d   = bus.NCYC;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Invalid cycles are stalls: signature and count both hold.
        if (bus.DIN_VLD) begin
          sig_d = sig_nxt;
          cnt_d = cnt_q - CNT_W'(1);
          // Leaving at a count of one keeps the counter from ever wrapping.
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status is decoded from the state register only, so no input reaches it.
  always_comb begin
    bus.BUSY = (state_q == ST_RUN);
    bus.DONE = (state_q == ST_DONE);
    bus.SIG  = sig_q;
  end

endmodule : misr_compactor

// File: tb/tb_misr_compactor.sv
// Scoreboard bench for misr_compactor (WIDTH=4, POLY=4'h3). Stimulus tasks
// queue the expected outputs for a given clock edge; a negedge monitor pops
// and compares them independently of the stimulus flow.
module tb_misr_compactor;

  localparam int TB_WIDTH = 4;
  localparam int TB_CNT_W = 8;

  typedef struct {
    int          cyc;
    logic [3:0]  sig;
    logic        busy;
    logic        done;
    string       name;
  } exp_t;

  logic clk;
  logic rstb;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];

  misr_compactor_if #(.WIDTH(TB_WIDTH), .CNT_W(TB_CNT_W)) bus ();

  misr_compactor #(
    .WIDTH (TB_WIDTH),
    .POLY  (4'h3),
    .CNT_W (TB_CNT_W)
  ) dut (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation queued for the edge just passed.
  always @(negedge clk) begin : mon
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for edge %0d missed (now edge %0d)", e.name, e.cyc, cyc);
      end else if (bus.SIG !== e.sig || bus.BUSY !== e.busy || bus.DONE !== e.done) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got sig=%h busy=%b done=%b, expected sig=%h busy=%b done=%b",
                 e.name, cyc, bus.SIG, bus.BUSY, bus.DONE, e.sig, e.busy, e.done);
      end else begin
        $display("ok   %s @edge %0d: sig=%h busy=%b done=%b", e.name, cyc, bus.SIG, bus.BUSY, bus.DONE);
      end
    end
  end

  task automatic push_exp(input int c, input logic [3:0] s, input logic b,
                          input logic d, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sig  = s;
    e.busy = b;
    e.done = d;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] seed, input logic [7:0] n,
                           input logic [3:0] es, input logic eb, input logic ed,
                           input string nm);
    bus.START   = 1'b1;
    bus.SEED    = seed;
    bus.NCYC    = n;
    bus.DIN_VLD = 1'b0;
    push_exp(cyc + 1, es, eb, ed, nm);
    step();
    bus.START = 1'b0;
  endtask

  task automatic sample(input logic [3:0] din, input logic [3:0] es,
                        input logic eb, input logic ed, input string nm);
    bus.DIN     = din;
    bus.DIN_VLD = 1'b1;
    push_exp(cyc + 1, es, eb, ed, nm);
    step();
    bus.DIN_VLD = 1'b0;
  endtask

  task automatic stall(input logic [3:0] es, input logic eb, input logic ed,
                       input string nm);
    bus.DIN_VLD = 1'b0;
    push_exp(cyc + 1, es, eb, ed, nm);
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rstb   = 1'b1;
    bus.START   = 1'b1;
    bus.NCYC    = 8'd3;
    bus.SEED    = 4'h5;
    bus.DIN     = 4'h0;
    bus.DIN_VLD = 1'b0;
    #1 rstb = 1'b0;

    // Reset held with START asserted: nothing may respond.
    push_exp(1, 4'h0, 1'b0, 1'b0, "rst_init");
    push_exp(2, 4'h0, 1'b0, 1'b0, "rst_start_ignored");
    step();
    step();

    // First START is taken on the first rise after release.
    rstb     = 1'b1;
    bus.SEED = 4'h0;
    bus.NCYC = 8'd3;
    bus.DIN  = 4'h1;
    push_exp(cyc + 1, 4'h0, 1'b1, 1'b0, "first_start");
    step();
    bus.START = 1'b0;
    sample(4'h1, 4'h1, 1'b1, 1'b0, "basic_s1");
    sample(4'h1, 4'h3, 1'b1, 1'b0, "basic_s2");
    sample(4'h1, 4'h7, 1'b0, 1'b1, "basic_done");
    sample(4'hF, 4'h7, 1'b0, 1'b1, "done_ignores_din");

    // Feedback tap: MSB set, zero data -> POLY.
    start_run(4'h8, 8'd1, 4'h8, 1'b1, 1'b0, "fb_start");
    sample(4'h0, 4'h3, 1'b0, 1'b1, "fb_done");

    // Zero-length run.
    start_run(4'hA, 8'd0, 4'hA, 1'b0, 1'b1, "zero_done");
    stall(4'hA, 1'b0, 1'b1, "zero_hold");

    // Stalls mid-run.
    start_run(4'h0, 8'd3, 4'h0, 1'b1, 1'b0, "stall_start");
    sample(4'h1, 4'h1, 1'b1, 1'b0, "stall_s1");
    stall(4'h1, 1'b1, 1'b0, "stall_gap1");
    stall(4'h1, 1'b1, 1'b0, "stall_gap2");
    sample(4'h1, 4'h3, 1'b1, 1'b0, "stall_s2");
    sample(4'h1, 4'h7, 1'b0, 1'b1, "stall_done");

    // START during RUN is ignored, START in DONE restarts.
    start_run(4'h0, 8'd3, 4'h0, 1'b1, 1'b0, "ign_start0");
    sample(4'h1, 4'h1, 1'b1, 1'b0, "ign_s1");
    bus.START = 1'b1;
    bus.SEED  = 4'hF;
    bus.NCYC  = 8'd0;
    sample(4'h1, 4'h3, 1'b1, 1'b0, "ign_start_mid");
    bus.START = 1'b0;
    sample(4'h1, 4'h7, 0, 1'b1, "ign_done");
    start_run(4'h5, 8'd2, 4'h5, 1'b1, 1'b0, "restart");
    sample(4'h0, 4'hA, 1'b1, 1'b0, "restart_s1");
    sample(4'h0, 4'h7, 1'b0, 1'b1, "restart_done");

    // Reset mid-run lands before the negedge check of the 2nd sample.
    start_run(4'h0, 8'd3, 4'h0, 1'b1, 1'b0, "rm_start");
    sample(4'h1, 4'h1, 1'b1, 1'b0, "rm_s1");
    sample(4'h1, 4'h0, 1'b0, 1'b0, "rm_async_clear");
    rstb      = 1'b0;
    bus.START = 1'b1;
    bus.SEED  = 4'h5;
    bus.NCYC  = 8'd2;
    stall(4'h0, 1'b0, 1'b0, "rm_held");
    bus.START = 1'b0;
    rstb      = 1'b1;
    start_run(4'h0, 8'd3, 4'h0, 1'b1, 1'b0, "rm_rerun_start");
    sample(4'h1, 4'h1, 1'b1, 1'b0, "rm_rerun_s1");
    sample(4'h1, 4'h3, 1'b1, 1'b0, "rm_rerun_s2");
    sample(4'h1, 4'h7, 1'b0, 1'b1, "rm_rerun_done");

    step();
    step();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_misr_compactor
